// File: rtl/seq_multiplier_if.sv
// Operand/result bundle between a multiply requester and seq_multiplier.
interface seq_multiplier_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             ld_out;
  logic [WIDTH-1:0] result;
  logic             ovf;

  modport master (
    output start, a, b,
    input  busy, done, ld_out, result, ovf
  );

  modport slave (
    input  start, a, b,
    output busy, done, ld_out, result, ovf
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative unsigned shift-and-add multiplier: 32 add/shift steps per product,
// then a one-cycle done/ld_out pulse carrying the low word and an overflow flag.
module seq_multiplier #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  seq_multiplier_if.slave    bus
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [PW-1:0]    acc, acc_nxt;
  logic [PW-1:0]    mcand, mcand_nxt;
  logic [PW-1:0]    sum;
  logic [WIDTH-1:0] mplier, mplier_nxt;
  logic [CW-1:0]    count, count_nxt;
  logic [WIDTH-1:0] result_q, result_nxt;
  logic             ovf_q, ovf_nxt;
  logic             busy_q, busy_nxt;
  logic             done_q, done_nxt;

  // State, datapath and registered outputs
  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      mcand    <= mcand_nxt;
      mplier   <= mplier_nxt;
      count    <= count_nxt;
      result_q <= result_nxt;
      ovf_q    <= ovf_nxt;
      busy_q   <= busy_nxt;
      done_q   <= done_nxt;
    end
  end

  // Next-state and next-datapath logic
  always_comb begin
    state_nxt  = state;
    acc_nxt    = acc;
    mcand_nxt  = mcand;
    mplier_nxt = mplier;
    count_nxt  = count;
    result_nxt = result_q;
    ovf_nxt    = ovf_q;
    sum        = mplier[0] ? (acc + mcand) : acc;

    case (state)
      IDLE: begin
        if (bus.start) begin
          acc_nxt    = '0;
          mcand_nxt  = PW'(bus.a);
          mplier_nxt = bus.b;
          count_nxt  = '0;
          state_nxt  = CALC;
        end
      end
      CALC: begin
        acc_nxt    = sum;
        mcand_nxt  = mcand << 1;
        mplier_nxt = mplier >> 1;
        count_nxt  = count + CW'(1);
        // Last step: publish the final sum directly, acc copy is now dead
        if (count == CW'(WIDTH - 1)) begin
          result_nxt = sum[WIDTH-1:0];
          ovf_nxt    = |sum[PW-1:WIDTH];
          state_nxt  = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase

    busy_nxt = (state_nxt == CALC) || (state_nxt == DONE);
    done_nxt = (state_nxt == DONE);
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.ld_out = done_q;
  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and random checks of seq_multiplier against a plain-arithmetic product model.
module tb_seq_multiplier;

  localparam int unsigned WIDTH = 32;

  logic clock = 1'b0;
  logic clear;

  seq_multiplier_if #(.WIDTH(WIDTH)) mif ();

  seq_multiplier #(.WIDTH(WIDTH)) dut (
    .clock (clock),
    .clear (clear),
    .bus   (mif)
  );

  always #5 clock = ~clock;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_res = '0;
  logic        last_ovf = 1'b0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction: accept, latency, product, pulse width, busy fall.
  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b, input string tag);
    logic [63:0] prod;
    int          lat;
    prod      = 64'(op_a) * 64'(op_b);
    mif.start = 1'b1;
    mif.a     = op_a;
    mif.b     = op_b;
    step();
    mif.start = 1'b0;
    mif.a     = $urandom;
    mif.b     = $urandom;
    chk({tag, "_busy_rise"}, 64'(mif.busy), 64'(1));
    chk({tag, "_hold_result"}, 64'(mif.result), 64'(last_res));
    chk({tag, "_hold_ovf"}, 64'(mif.ovf), 64'(last_ovf));
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (mif.done) begin
        lat = n;
        break;
      end
      step();
    end
    chk({tag, "_latency"}, 64'(lat), 64'(33));
    chk({tag, "_result"}, 64'(mif.result), 64'(prod[31:0]));
    chk({tag, "_ovf"}, 64'(mif.ovf), 64'(prod[63:32] != 32'd0));
    chk({tag, "_ld_out"}, 64'(mif.ld_out), 64'(1));
    step();
    chk({tag, "_done_fall"}, 64'(mif.done), 64'(0));
    chk({tag, "_busy_fall"}, 64'(mif.busy), 64'(0));
    last_res = prod[31:0];
    last_ovf = (prod[63:32] != 32'd0);
  endtask

  initial begin
    int ndone;
    int dn;
    int k;
    int t0;
    int t1;

    // Reset
    clear     = 1'b1;
    mif.start = 1'b0;
    mif.a     = '0;
    mif.b     = '0;
    step(); step(); step();
    chk("rst_busy", 64'(mif.busy), 64'(0));
    chk("rst_done", 64'(mif.done), 64'(0));
    chk("rst_ld_out", 64'(mif.ld_out), 64'(0));
    chk("rst_result", 64'(mif.result), 64'(0));
    chk("rst_ovf", 64'(mif.ovf), 64'(0));
    clear = 1'b0;
    step();

    // Directed products
    run_op(32'd7, 32'd6, "m7x6");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "mmax");
    run_op(32'h0001_0000, 32'h0001_0000, "m2p32");
    run_op(32'd0, 32'h1234_5678, "mzero");

    // Starts during CALC and DONE are ignored
    mif.start = 1'b1;
    mif.a     = 32'd3;
    mif.b     = 32'd5;
    step();
    ndone = 0;
    dn    = 0;
    for (int n = 1; n <= 45; n++) begin
      if (n == 5 || n == 33) begin
        mif.start = 1'b1;
        mif.a     = 32'd9;
        mif.b     = 32'd9;
      end else begin
        mif.start = 1'b0;
      end
      if (mif.done) begin
        ndone++;
        dn = n;
        chk("ign_result", 64'(mif.result), 64'(15));
      end
      step();
    end
    mif.start = 1'b0;
    chk("ign_done_count", 64'(ndone), 64'(1));
    chk("ign_done_cycle", 64'(dn), 64'(33));
    chk("ign_busy_after", 64'(mif.busy), 64'(0));
    chk("ign_result_after", 64'(mif.result), 64'(15));
    last_res = 32'd15;
    last_ovf = 1'b0;

    // Clear aborts a running multiply
    mif.start = 1'b1;
    mif.a     = 32'd100;
    mif.b     = 32'd100;
    step();
    mif.start = 1'b0;
    for (int n = 1; n < 10; n++) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_busy", 64'(mif.busy), 64'(0));
    chk("clr_result", 64'(mif.result), 64'(0));
    chk("clr_ovf", 64'(mif.ovf), 64'(0));
    ndone = 0;
    for (int n = 0; n < 40; n++) begin
      if (mif.done) ndone++;
      step();
    end
    chk("clr_no_done", 64'(ndone), 64'(0));
    last_res = '0;
    last_ovf = 1'b0;
    run_op(32'd2, 32'd3, "m2x3_after_clr");

    // Start held high: back-to-back accepts 34 cycles apart
    mif.start = 1'b1;
    mif.a     = 32'd4;
    mif.b     = 32'd4;
    step();
    k  = 0;
    t0 = 0;
    t1 = 0;
    for (int n = 1; n <= 80; n++) begin
      if (mif.done) begin
        if (k == 0) t0 = n;
        else        t1 = n;
        k++;
        chk("held_result", 64'(mif.result), 64'(16));
        if (k == 2) mif.start = 1'b0;
      end
      step();
    end
    mif.start = 1'b0;
    chk("held_done_count", 64'(k), 64'(2));
    chk("held_first_done", 64'(t0), 64'(33));
    chk("held_second_done", 64'(t1), 64'(67));
    last_res = 32'd16;
    last_ovf = 1'b0;

    // Random operands
    for (int i = 0; i < 10; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      if (i == 0) rb = 32'd1;
      if (i == 1) ra = ra & 32'h0000_FFFF;
      if (i == 1) rb = rb & 32'h0000_FFFF;
      run_op(ra, rb, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Iterative 32×32 unsigned shift-and-add multiplier. It sits directly upstream of a 32-bit load/clear result register: it accepts two operands on a start pulse and computes the product over 32 cycles. It then presents the low 32 bits on `result` and pulses `ld_out` for one cycle so the downstream register captures the product.

## Interface
- `WIDTH`, 32: operand and result width. Only 32 is supported.
- `clock` input 1: single clock, rising edge.
- `clear` input 1: synchronous, active-high reset.
- `start` input 1: request a multiply. Sampled only in IDLE.
- `a` input 32: multiplicand, captured on the accepted start.
- `b` input 32: multiplier, captured on the accepted start.
- `busy` output 1: high in CALC and DONE.
- `done` output 1: one-cycle pulse in DONE.
- `ld_out` output 1: equal to `done`. Drives the result register's `ld`.
- `result` output 32: low 32 bits of a×b. Valid from DONE until the next accepted start.
- `ovf` output 1: high when the full product is ≥ 2^32. Same validity as `result`.

## Operation
- Internal state:
  - 64-bit `acc` and 64-bit `mcand`
  - 32-bit `mplier`
  - 5-bit `count`
  - 2-bit state register
- IDLE:
  - `busy`=0, `done`=0.
  - On `start`=1: load `mcand`={32'b0,a}, `mplier`=b, `acc`=0, `count`=0, then go to CALC.
  - `result` and `ovf` are not changed by the accepted start itself.
- CALC, each cycle:
  - If `mplier`[0]: `acc` ← `acc`+`mcand`, mod 2^64. No carry out is possible.
  - `mcand` ← `mcand`<<1; `mplier` ← `mplier`>>1; `count` ← `count`+1.
  - On the cycle where `count`==31: go to DONE, and register `result` ← low 32 bits of the final sum and `ovf` ← (high 32 bits of the final sum ≠ 0).
  - The iteration count is always exactly 32. There is no early exit on zero operands.
- DONE: `done`=`ld_out`=1 for exactly one cycle, then unconditionally go to IDLE.
- `start` while in CALC or DONE is ignored; no queueing.
- Reachable states: IDLE=0, CALC=1, DONE=2. The unused encoding goes to IDLE on the next edge.

## Timing
- Reset value of every output on `clear`=1: `busy`=0, `done`=0, `ld_out`=0, `result`=0, `ovf`=0.
- On `clear`=1, state returns to IDLE and all internal registers go to 0.
- `clear` wins over all other inputs, including mid-CALC and in DONE. An aborted operation produces no `done`.
- Let E0 be the edge at which `start` is accepted:
  - CALC occupies the cycles after E0 through E32.
  - DONE is the cycle after E32, with `done` high.
  - IDLE is re-entered at E33.
  - Latency is 33 cycles from accept to the `done` cycle.
- Minimum issue interval is 34 cycles. A `start` held high continuously is re-accepted in the first IDLE cycle after DONE.
- `busy` rises in the cycle after E0 and falls in the cycle after the DONE cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.
- `result`/`ovf` timing relative to the downstream register:
  - They are stable during the DONE cycle, so the downstream register latches them on the edge that ends DONE.
  - They hold their value through IDLE and the next CALC until the next DONE or `clear`.

## Test plan
- a=7, b=6, start pulse:
  - `done` goes high exactly 33 cycles after the accept edge, for one cycle.
  - `result`=42, `ovf`=0, `ld_out`=`done`.
- a=0xFFFFFFFF, b=0xFFFFFFFF → `result`=0x00000001, `ovf`=1.
- a=0x00010000, b=0x00010000 → `result`=0, `ovf`=1.
- a=0, b=0x12345678 → `result`=0, `ovf`=0, and the latency is still 33 cycles.
- Start 3×5, then pulse `start` with 9×9 at cycles 5 and 33 after the accept:
  - Both pulses are ignored.
  - `result`=15, and there is exactly one `done`.
- Start 100×100, assert `clear` at cycle 10 of CALC:
  - The next cycle shows `busy`=0 and `result`=0, and no `done` follows.
  - A fresh start with 2×3 then yields `result`=6 after 33 cycles.
- Hold `start`=1 with a=4, b=4: `done` pulses at 33 cycles and again 34 cycles later, each with `result`=16.
